pellet_controller: RTL and testbench
====================================

# pellet_controller

Sequencing and arbitration controller for the maze pellet store. It owns a single-port 1200×1 pellet RAM and time-slices it between the VGA tile reader and the game-logic "eat" requester. It refills the RAM from the level init ROM on reset or on request, and maintains the remaining-pellet count and level-clear flag. It sits between the sprite/draw pipeline, the pacman movement logic, and the score/level FSM.

## Interface
- NUM_TILES, 1200, number of maze tiles (40×30)
- ADDR_W, 11, tile index width
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high; enters REFILL
- refill_req  in  1  single-cycle pulse; restart level refill
- disp_index  in  ADDR_W  tile index requested by the draw pipeline
- disp_pellet  out  1  pellet bit for the last sampled disp_index
- eat_valid  in  1  eat request
- eat_index  in  ADDR_W  tile pacman occupies
- eat_ready  out  1  request accepted when eat_valid & eat_ready
- eat_done  out  1  one-cycle pulse, eat transaction complete
- eat_hit  out  1  valid with eat_done; 1 = a pellet was consumed
- pellets_left  out  ADDR_W  remaining pellets
- level_clear  out  1  high while no pellets remain (after refill)
- refilling  out  1  high during REFILL
- init_addr  out  ADDR_W  init ROM address
- init_data  in  1  init ROM data, 1-cycle registered read
- ram_addr  out  ADDR_W; ram_we  out  1; ram_wdata  out  1; ram_rdata  in  1  (pellet_ram port, 1-cycle read latency)

## Operation
- `slot` toggles every cycle and is 0 after Reset. Slot 0 is the display slot: ram_addr = disp_index, ram_we = 0. Slot 1 is the controller slot.
- ram_rdata seen in a slot-1 cycle belongs to the display; in a slot-0 cycle it belongs to the controller.
- States: REFILL, IDLE, EAT_RD, EAT_WR, CLEARED.
- REFILL
  - tile counter t runs from 0 to NUM_TILES-1.
  - Slot 0: init_addr = t.
  - Slot 1: ram_addr = t, ram_we = 1, ram_wdata = init_data; pellets_left += init_data; t++.
  - After tile NUM_TILES-1: go to IDLE if pellets_left ≠ 0, else CLEARED.
- IDLE
  - eat_ready = ~refill_req.
  - On accept, latch eat_index and go to EAT_RD.
  - An index ≥ NUM_TILES completes immediately: eat_done = 1, eat_hit = 0, no RAM access, stay in IDLE.
- EAT_RD
  - On the next slot-1 cycle, issue a read of the latched index.
  - In the following slot-0 cycle, capture ram_rdata and go to EAT_WR.
- EAT_WR
  - On the next slot-1 cycle: if the captured bit is 1, write 0, decrement pellets_left, and pulse eat_done with eat_hit = 1. Otherwise pulse eat_done with eat_hit = 0 and no write.
  - Next state: CLEARED if pellets_left becomes 0, else IDLE.
- CLEARED
  - level_clear = 1 and eat_ready = 0.
  - Leave only via refill_req or Reset.
- refill_req in any state:
  - next state REFILL; t = 0, pellets_left = 0.
  - An in-flight eat is aborted with no eat_done.
  - Refill beats eat when both arrive in the same cycle.
- disp_pellet is forced to 0 while refilling = 1.
- pellets_left never underflows; it can only decrement on a read bit of 1.

## Timing
- Reset values: disp_pellet 0, eat_ready 0, eat_done 0, eat_hit 0, pellets_left 0, level_clear 0, refilling 1, slot 0, t 0.
- Display latency: disp_index sampled in a slot-0 cycle gives disp_pellet registered at the end of the next (slot-1) cycle. disp_pellet holds for 2 cycles. The draw pipeline must hold disp_index ≥ 2 cycles (tiles are 16 pixels wide, so this holds).
- Eat latency: accept to eat_done is 3 or 4 cycles, depending on slot phase. Throughput is one eat per 4 cycles.
- Refill takes exactly 2·NUM_TILES = 2400 cycles from entering REFILL. refilling falls in the cycle the next state is loaded.
- eat_done and eat_hit are registered single-cycle pulses; eat_hit is 0 when eat_done is 0.

## Structure
- Package pellet_pkg holds NUM_TILES, ADDR_W and the state enum.
- Sub-module pellet_ram: single-port synchronous 1200×1 RAM with registered read. It is instantiated outside the controller.
- The init ROM is external.

## Test plan
- Reset, then an init ROM with pellets at indices 0, 5 and 1199 → refilling high for 2400 cycles, then pellets_left = 3, state IDLE, level_clear = 0.
- Eat index 5 → eat_done with eat_hit = 1 within 4 cycles, pellets_left = 2. Eat 5 again → eat_hit = 0, pellets_left stays 2.
- Display sweeps 0..1199 concurrently with eats → disp_pellet matches the model with 2-cycle latency; no corruption from interleaved writes.
- Eat 0, then eat 1199 → after the last eat, pellets_left = 0, level_clear = 1 and eat_ready = 0 until refill_req.
- refill_req during EAT_WR, and refill_req in the same cycle as eat_valid → no eat_done, RAM fully restored, pellets_left = 3.
- eat_index = 1500 → immediate eat_done with eat_hit = 0, no ram_we, pellets_left unchanged.

Source files
------------

// File: rtl/pellet_pkg.sv
// Shared constants and state encoding for the maze pellet store.
package pellet_pkg;

    localparam int NUM_TILES = 1200;
    localparam int ADDR_W    = 11;

    localparam logic [ADDR_W-1:0] TILE_END  = ADDR_W'(NUM_TILES);
    localparam logic [ADDR_W-1:0] LAST_TILE = ADDR_W'(NUM_TILES - 1);

    typedef enum logic [2:0] {
        REFILL,
        IDLE,
        EAT_RD,
        EAT_WR,
        CLEARED
    } state_t;

endpackage

// File: rtl/pellet_if.sv
// Eat request/response bundle between the pacman movement logic and the pellet controller.
interface pellet_if;
    import pellet_pkg::*;

    logic              eat_valid;
    logic [ADDR_W-1:0] eat_index;
    logic              eat_ready;
    logic              eat_done;
    logic              eat_hit;

    modport master (output eat_valid, eat_index, input eat_ready, eat_done, eat_hit);
    modport slave  (input eat_valid, eat_index, output eat_ready, eat_done, eat_hit);

endinterface

// File: rtl/pellet_ram.sv
// Single-port 1200x1 pellet RAM, synchronous write and registered read.
module pellet_ram
    import pellet_pkg::*;
(
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic              wdata,
    output logic              rdata
);

    logic mem [NUM_TILES];
    logic rdata_q;

    always_ff @(posedge clk) begin
        if (addr < TILE_END) begin
            if (we) mem[addr] <= wdata;
            rdata_q <= mem[addr];
        end else begin
            rdata_q <= 1'b0;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pellet_controller.sv
// Time-slices the pellet RAM between the display reader and eat requests,
// refills it from the level ROM and tracks the remaining pellet count.
module pellet_controller
    import pellet_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              refill_req,
    input  logic [ADDR_W-1:0] disp_index,
    output logic              disp_pellet,
    pellet_if.slave           eat,
    output logic [ADDR_W-1:0] pellets_left,
    output logic              level_clear,
    output logic              refilling,
    output logic [ADDR_W-1:0] init_addr,
    input  logic              init_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              ram_wdata,
    input  logic              ram_rdata
);

    state_t            state_q, state_d;
    logic              slot_q, slot_d;
    logic [ADDR_W-1:0] t_q, t_d;
    logic [ADDR_W-1:0] left_q, left_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              cap_q, cap_d;
    logic              rd_pend_q, rd_pend_d;
    logic              done_q, done_d;
    logic              hit_q, hit_d;
    logic              disp_q, disp_d;
    logic              eat_ready;
    logic              consume;

    assign eat_ready = (state_q == IDLE) && !refill_req;
    assign consume   = cap_q && (left_q != '0);

    always_comb begin
        state_d   = state_q;
        slot_d    = ~slot_q;
        t_d       = t_q;
        left_d    = left_q;
        idx_d     = idx_q;
        cap_d     = cap_q;
        rd_pend_d = rd_pend_q;
        done_d    = 1'b0;
        hit_d     = 1'b0;
        disp_d    = disp_q;
        ram_addr  = disp_index;
        ram_we    = 1'b0;
        ram_wdata = 1'b0;

        // Read data arriving in slot 1 answers the display address issued in slot 0.
        if (slot_q) disp_d = ram_rdata;

        unique case (state_q)
            REFILL: begin
                disp_d = 1'b0;
                if (slot_q) begin
                    ram_addr  = t_q;
                    ram_we    = 1'b1;
                    ram_wdata = init_data;
                    left_d    = left_q + ADDR_W'(init_data);
                    if (t_q == LAST_TILE) begin
                        t_d     = '0;
                        state_d = (left_d != '0) ? IDLE : CLEARED;
                    end else begin
                        t_d = t_q + ADDR_W'(1);
                    end
                end
            end
            IDLE: begin
                if (eat.eat_valid && eat_ready) begin
                    if (eat.eat_index >= TILE_END) begin
                        done_d = 1'b1;
                    end else begin
                        idx_d     = eat.eat_index;
                        rd_pend_d = 1'b0;
                        state_d   = EAT_RD;
                    end
                end
            end
            EAT_RD: begin
                if (slot_q) begin
                    ram_addr  = idx_q;
                    rd_pend_d = 1'b1;
                end else if (rd_pend_q) begin
                    cap_d     = ram_rdata;
                    rd_pend_d = 1'b0;
                    state_d   = EAT_WR;
                end
            end
            EAT_WR: begin
                if (slot_q) begin
                    done_d = 1'b1;
                    hit_d  = consume;
                    if (consume) begin
                        ram_addr  = idx_q;
                        ram_we    = 1'b1;
                        ram_wdata = 1'b0;
                        left_d    = left_q - ADDR_W'(1);
                    end
                    state_d = (left_d == '0) ? CLEARED : IDLE;
                end
            end
            CLEARED: ;
            default: state_d = REFILL;
        endcase

        // A refill always restarts in the display slot so it lasts exactly 2*NUM_TILES cycles.
        if (refill_req) begin
            state_d   = REFILL;
            slot_d    = 1'b0;
            t_d       = '0;
            left_d    = '0;
            rd_pend_d = 1'b0;
            done_d    = 1'b0;
            hit_d     = 1'b0;
            disp_d    = 1'b0;
            ram_we    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= REFILL;
            slot_q    <= 1'b0;
            t_q       <= '0;
            left_q    <= '0;
            rd_pend_q <= 1'b0;
            done_q    <= 1'b0;
            hit_q     <= 1'b0;
            disp_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            t_q       <= t_d;
            left_q    <= left_d;
            rd_pend_q <= rd_pend_d;
            done_q    <= done_d;
            hit_q     <= hit_d;
            disp_q    <= disp_d;
        end
    end

    always_ff @(posedge clk) begin
        idx_q <= idx_d;
        cap_q <= cap_d;
    end

    assign eat.eat_ready = eat_ready;
    assign eat.eat_done  = done_q;
    assign eat.eat_hit   = hit_q;
    assign disp_pellet   = disp_q;
    assign pellets_left  = left_q;
    assign level_clear   = (state_q == CLEARED);
    assign refilling     = (state_q == REFILL);
    assign init_addr     = t_q;

endmodule

// File: tb/tb_pellet_controller.sv
// Bench for pellet_controller with the pellet RAM and a behavioural level ROM.
module tb_pellet_controller;
    import pellet_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              refill_req;
    logic [ADDR_W-1:0] disp_index;
    logic              disp_pellet;
    logic [ADDR_W-1:0] pellets_left;
    logic              level_clear;
    logic              refilling;
    logic [ADDR_W-1:0] init_addr;
    logic              init_data;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic              ram_wdata;
    logic              ram_rdata;

    pellet_if eat_bus ();

    pellet_controller dut (
        .clk          (clk),
        .rst          (rst),
        .refill_req   (refill_req),
        .disp_index   (disp_index),
        .disp_pellet  (disp_pellet),
        .eat          (eat_bus),
        .pellets_left (pellets_left),
        .level_clear  (level_clear),
        .refilling    (refilling),
        .init_addr    (init_addr),
        .init_data    (init_data),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    pellet_ram u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    logic rom_bits [NUM_TILES];
    always @(posedge clk) init_data <= (init_addr < TILE_END) ? rom_bits[init_addr] : 1'b0;

    int we_cnt;
    always @(posedge clk) begin
        if (rst) we_cnt <= 0;
        else if (ram_we === 1'b1) we_cnt <= we_cnt + 1;
    end

    bit model_ram [NUM_TILES];
    int model_count;
    int tests;
    int failed;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_ram(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < NUM_TILES; i++)
            if (u_ram.mem[i] !== model_ram[i]) bad++;
        chk(tag, bad, 0);
    endtask

    // Called in the first refill cycle; the model becomes a copy of the ROM.
    task automatic wait_refill();
        int n;
        int disp_bad;
        int done_cnt;
        n = 0;
        disp_bad = 0;
        done_cnt = 0;
        while (refilling === 1'b1 && n < 3000) begin
            if (disp_pellet !== 1'b0) disp_bad++;
            if (eat_bus.eat_done !== 1'b0) done_cnt++;
            tick();
            n++;
        end
        chk("refill_cycles", n, 2 * NUM_TILES);
        chk("disp_zero_in_refill", disp_bad, 0);
        chk("no_eat_done_in_refill", done_cnt, 0);
        model_count = 0;
        for (int i = 0; i < NUM_TILES; i++) begin
            model_ram[i] = rom_bits[i];
            if (rom_bits[i]) model_count++;
        end
        chk("pellets_after_refill", pellets_left, model_count);
        chk("level_clear_after_refill", level_clear, model_count == 0);
    endtask

    task automatic request_refill();
        refill_req = 1'b1;
        tick();
        refill_req = 1'b0;
        chk("refilling_after_req", refilling, 1);
        chk("pellets_zero_in_refill", pellets_left, 0);
        wait_refill();
    endtask

    task automatic do_eat(input int idx);
        logic exp_hit;
        int   n;
        int   we0;
        exp_hit = (idx < NUM_TILES) ? model_ram[idx] : 1'b0;
        chk("eat_ready_idle", eat_bus.eat_ready, 1);
        eat_bus.eat_valid = 1'b1;
        eat_bus.eat_index = ADDR_W'(idx);
        we0 = we_cnt;
        tick();
        eat_bus.eat_valid = 1'b0;
        n = 0;
        while (eat_bus.eat_done !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk($sformatf("eat_done_seen_%0d", idx), eat_bus.eat_done, 1);
        chk($sformatf("eat_hit_%0d", idx), eat_bus.eat_hit, exp_hit);
        if (idx < NUM_TILES) chk("eat_latency_3_or_4", (n == 3 || n == 4), 1);
        else chk("eat_latency_immediate", n, 0);
        if (exp_hit) begin
            model_ram[idx] = 1'b0;
            model_count--;
        end
        chk("eat_ram_writes", we_cnt - we0, exp_hit);
        chk("eat_pellets_left", pellets_left, model_count);
        chk("eat_level_clear", level_clear, model_count == 0);
        tick();
        chk("eat_done_single_pulse", eat_bus.eat_done, 0);
        chk("eat_hit_low_without_done", eat_bus.eat_hit, 0);
    endtask

    // Holds an index for 4 cycles; a tile eaten during the hold may legitimately show either value.
    task automatic disp_check(input int i);
        bit old_b;
        disp_index = ADDR_W'(i);
        old_b = model_ram[i];
        tick();
        tick();
        tick();
        if (old_b == model_ram[i]) chk($sformatf("disp_%0d", i), disp_pellet, old_b);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, failed);
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt;
        tests = 0;
        failed = 0;
        rst = 1'b1;
        refill_req = 1'b0;
        disp_index = '0;
        eat_bus.eat_valid = 1'b0;
        eat_bus.eat_index = '0;
        for (int i = 0; i < NUM_TILES; i++) rom_bits[i] = (i == 0 || i == 5 || i == NUM_TILES - 1);

        tick();
        chk("rst_refilling", refilling, 1);
        chk("rst_eat_ready", eat_bus.eat_ready, 0);
        chk("rst_eat_done", eat_bus.eat_done, 0);
        chk("rst_eat_hit", eat_bus.eat_hit, 0);
        chk("rst_pellets_left", pellets_left, 0);
        chk("rst_level_clear", level_clear, 0);
        chk("rst_disp_pellet", disp_pellet, 0);
        tick();
        tick();
        rst = 1'b0;
        wait_refill();
        chk("idle_after_reset_refill", eat_bus.eat_ready, 1);
        check_ram("ram_after_reset_refill");

        disp_check(0);
        disp_check(1);
        disp_check(5);
        disp_check(6);
        disp_check(NUM_TILES - 2);
        disp_check(NUM_TILES - 1);

        do_eat(5);
        do_eat(5);
        do_eat(1500);
        do_eat(0);
        do_eat(NUM_TILES - 1);
        chk("cleared_level_clear", level_clear, 1);
        chk("cleared_eat_ready", eat_bus.eat_ready, 0);

        done_cnt = 0;
        eat_bus.eat_valid = 1'b1;
        eat_bus.eat_index = ADDR_W'(6);
        for (int k = 0; k < 6; k++) begin
            tick();
            if (eat_bus.eat_done !== 1'b0) done_cnt++;
        end
        eat_bus.eat_valid = 1'b0;
        chk("cleared_ignores_eat", done_cnt, 0);
        chk("cleared_holds", level_clear, 1);
        chk("cleared_pellets", pellets_left, 0);

        request_refill();
        check_ram("ram_after_refill_req");

        // Refill just finished, so this cycle is a display slot: accept, read, capture, then EAT_WR.
        eat_bus.eat_valid = 1'b1;
        eat_bus.eat_index = ADDR_W'(5);
        tick();
        eat_bus.eat_valid = 1'b0;
        tick();
        tick();
        refill_req = 1'b1;
        tick();
        refill_req = 1'b0;
        chk("abort_no_done", eat_bus.eat_done, 0);
        chk("abort_refilling", refilling, 1);
        wait_refill();
        check_ram("ram_after_abort");

        eat_bus.eat_valid = 1'b1;
        eat_bus.eat_index = ADDR_W'(5);
        refill_req = 1'b1;
        #0;
        chk("refill_beats_eat_ready", eat_bus.eat_ready, 0);
        tick();
        eat_bus.eat_valid = 1'b0;
        refill_req = 1'b0;
        chk("refill_beats_eat_done", eat_bus.eat_done, 0);
        wait_refill();
        check_ram("ram_after_refill_vs_eat");

        for (int i = 0; i < NUM_TILES; i++) rom_bits[i] = 1'($urandom_range(0, 1));
        request_refill();
        check_ram("ram_after_random_refill");

        fork
            begin
                for (int i = 0; i < NUM_TILES; i++) disp_check(i);
            end
            begin
                for (int e = 0; e < 250; e++) begin
                    do_eat(int'($urandom_range(0, NUM_TILES + 99)));
                    for (int g = int'($urandom_range(0, 3)); g > 0; g--) tick();
                end
            end
        join
        chk("random_pellets_left", pellets_left, model_count);
        check_ram("ram_after_random_eats");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
